// File: rtl/i2c_slave_rx_ctrl.sv
// i2c_slave_rx_ctrl
// I2C slave write-path receiver. Oversamples raw SCL/SDA on FPGA_clk,
// detects START/STOP, matches a 7-bit address (write only) and ACKs/NACKs
// each byte. Accepted data bytes are presented on a single-entry
// valid/ready interface with backpressure.
//
// Ports:
//   FPGA_clk    system clock (>= 10x SCL rate)
//   rst         asynchronous active-high reset
//   SCL, SDA    raw bus inputs (asynchronous)
//   enable      slave enable, sampled when a START is seen in IDLE
//   sda_pull    1 = drive SDA low (open-drain enable)
//   rx_data     received byte
//   rx_valid    rx_data holds an unconsumed byte
//   rx_ready    sink accepts rx_data on rx_valid & rx_ready
//   byte_index  0-based position of rx_data within its frame
//   busy        addressed frame in progress
//   frame_done  one-cycle pulse when STOP ends an addressed frame
//   overrun     sticky: a byte was NACKed because the output slot was full
module i2c_slave_rx_ctrl #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         NUM_BYTES   = 6,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       FPGA_clk,
  input  logic       rst,
  input  logic       SCL,
  input  logic       SDA,
  input  logic       enable,
  output logic       sda_pull,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] byte_index,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [7:0] MAX_BYTES = 8'(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers plus one history flop per line. They reset to 1 (idle bus)
  // so leaving reset never fabricates a START.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_hist_reg, sda_hist_reg;

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], SCL};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], SDA};
      scl_hist_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_hist_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev;

  assign scl_s    = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s    = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_reg;
  assign scl_fall = ~scl_s & scl_hist_reg;
  assign sda_rise = sda_s & ~sda_hist_reg;
  assign sda_fall = ~sda_s & sda_hist_reg;
  assign start_ev = sda_fall & scl_s;
  assign stop_ev  = sda_rise & scl_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic       ack_phase_reg, ack_phase_next;  // 0: wait first SCL fall, 1: holding
  logic       ack_reg, ack_next;
  logic       sda_pull_reg, sda_pull_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic [7:0] byte_index_reg, byte_index_next;
  logic       busy_reg, busy_next;
  logic       frame_done_reg, frame_done_next;
  logic       overrun_reg, overrun_next;

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      byte_cnt_reg   <= '0;
      ack_phase_reg  <= 1'b0;
      ack_reg        <= 1'b0;
      sda_pull_reg   <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      byte_index_reg <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      byte_cnt_reg   <= byte_cnt_next;
      ack_phase_reg  <= ack_phase_next;
      ack_reg        <= ack_next;
      sda_pull_reg   <= sda_pull_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      byte_index_reg <= byte_index_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Byte as it stands once the current SDA bit is shifted in.
  logic [7:0] byte_in;
  logic       last_bit;
  logic       slot_free;

  assign byte_in   = {shift_reg, sda_s};
  assign last_bit  = scl_rise && (bit_cnt_reg == 3'd7);
  // The slot counts as free when the sink drains it in the same cycle.
  assign slot_free = ~rx_valid_reg | rx_ready;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    byte_cnt_next   = byte_cnt_reg;
    ack_phase_next  = ack_phase_reg;
    ack_next        = ack_reg;
    sda_pull_next   = sda_pull_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = rx_valid_reg;
    byte_index_next = byte_index_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;

    // Consumption; a load below in the same cycle overrides this.
    if (rx_valid_reg && rx_ready) rx_valid_next = 1'b0;

    if (stop_ev) begin
      state_next      = IDLE;
      sda_pull_next   = 1'b0;
      busy_next       = 1'b0;
      ack_phase_next  = 1'b0;
      frame_done_next = busy_reg;
    end else if (start_ev) begin
      // Repeated start restarts the address phase but leaves busy and the
      // output slot alone until the new address is decided.
      bit_cnt_next   = '0;
      byte_cnt_next  = '0;
      overrun_next   = 1'b0;
      ack_phase_next = 1'b0;
      sda_pull_next  = 1'b0;
      if (state_reg != IDLE || enable) state_next = ADDR;
    end else begin
      unique case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next   = byte_in[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (last_bit) begin
              ack_phase_next = 1'b0;
              if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0]) begin
                state_next = ADDR_ACK;
                busy_next  = 1'b1;
                ack_next   = 1'b1;
              end else begin
                state_next = IGNORE;
                busy_next  = 1'b0;
              end
            end
          end
        end

        DATA: begin
          if (scl_rise) begin
            shift_next   = byte_in[6:0];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (last_bit) begin
              state_next     = DATA_ACK;
              ack_phase_next = 1'b0;
              if (byte_cnt_reg < MAX_BYTES && slot_free) begin
                ack_next        = 1'b1;
                rx_data_next    = byte_in;
                rx_valid_next   = 1'b1;
                byte_index_next = byte_cnt_reg;
                byte_cnt_next   = byte_cnt_reg + 8'd1;
              end else begin
                ack_next = 1'b0;
                if (!slot_free) overrun_next = 1'b1;
              end
            end
          end
        end

        // The 9th clock: drive from the fall after bit 8 to the fall after
        // the ACK clock, so the hold time after SCL fall is the sync latency.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              ack_phase_next = 1'b1;
              sda_pull_next  = ack_reg;
            end else begin
              ack_phase_next = 1'b0;
              sda_pull_next  = 1'b0;
              state_next     = DATA;
            end
          end
        end

        default: begin
          // IDLE and IGNORE only react to START/STOP.
        end
      endcase
    end
  end

  assign sda_pull   = sda_pull_reg;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign byte_index = byte_index_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Testbench for i2c_slave_rx_ctrl: bit-banged I2C master on a wired-AND SDA,
// table of write frames plus hand-written repeated-start and reset sequences.
// Delivered bytes are checked against a scoreboard queue filled when the
// master sends a byte it expects to be ACKed.
module tb_i2c_slave_rx_ctrl;

  logic       FPGA_clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       enable;
  logic       rx_ready;
  logic       sda_pull;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] byte_index;
  logic       busy;
  logic       frame_done;
  logic       overrun;
  logic       scl_bus, sda_bus;

  assign scl_bus = scl_m;
  assign sda_bus = sda_m & ~sda_pull;

  always #5 FPGA_clk = ~FPGA_clk;

  i2c_slave_rx_ctrl #(
    .SLAVE_ADDR (7'h42),
    .NUM_BYTES  (6),
    .SYNC_STAGES(2)
  ) dut (
    .FPGA_clk  (FPGA_clk),
    .rst       (rst),
    .SCL       (scl_bus),
    .SDA       (sda_bus),
    .enable    (enable),
    .sda_pull  (sda_pull),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .byte_index(byte_index),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  localparam int Q = 8;  // quarter SCL period in FPGA_clk cycles

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] index;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [7:0]      addr_byte;
    int              nbytes;
    logic [7:0][7:0] data;      // byte j in lane j (lane 0 = low bits)
    logic            ready;
    logic            addr_ack;
    logic [7:0]      ack_mask;  // bit j = byte j expected ACKed
    int              exp_fd;
    logic            exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Sink side: a handshake seen at negedge completes on the next posedge.
  always @(negedge FPGA_clk) begin
    if (frame_done) fd_count++;
    if (!rst && rx_valid && rx_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx: got data=%02h index=%0d required no byte", rx_data, byte_index);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("rx byte data=%02h index=%0d (expected %02h/%0d)", rx_data, byte_index, e.data, e.index);
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("byte_index", 32'(byte_index), 32'(e.index));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge FPGA_clk);
    #1;
  endtask

  // Works from idle (SCL high) and as a repeated start (SCL low).
  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    $display("byte %02h %s ack: sda_pull=%0b expected %0b", b, name, sda_pull, exp_ack);
    check({name, "_ack"}, 32'(sda_pull), 32'(exp_ack));
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int base;
    int idx;
    logic a;
    rx_ready = v.ready;
    base = fd_count;
    idx = 0;
    i2c_start();
    send_byte(v.addr_byte, v.addr_ack, $sformatf("v%0d_addr", vi));
    check($sformatf("v%0d_busy_in_frame", vi), 32'(busy), 32'(v.addr_ack));
    for (int j = 0; j < v.nbytes; j++) begin
      a = v.ack_mask[j];
      if (a) begin
        sb_q.push_back('{data: v.data[j], index: 8'(idx)});
        idx++;
      end
      send_byte(v.data[j], a, $sformatf("v%0d_d%0d", vi, j));
    end
    i2c_stop();
    wait_clks(10);
    check($sformatf("v%0d_frame_done_cycles", vi), 32'(fd_count - base), 32'(v.exp_fd));
    check($sformatf("v%0d_busy_after_stop", vi), 32'(busy), 32'd0);
    check($sformatf("v%0d_overrun", vi), 32'(overrun), 32'(v.exp_ovr));
    rx_ready = 1'b1;
    wait_clks(10);
    check($sformatf("v%0d_sb_empty", vi), 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_pull"}, 32'(sda_pull), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_byte_index"}, 32'(byte_index), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    // addr, n, data (lane 0 first), ready, addr_ack, ack_mask, fd, ovr
    vecs[0] = '{8'h84, 3, 64'h00000000_00FF3CA5, 1'b1, 1'b1, 8'h07, 1, 1'b0};
    vecs[1] = '{8'h86, 1, 64'h00000000_00000055, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    vecs[2] = '{8'h85, 0, 64'h0,                  1'b1, 1'b0, 8'h00, 0, 1'b0};
    vecs[3] = '{8'h84, 8, 64'h08070605_04030201, 1'b1, 1'b1, 8'h3F, 1, 1'b0};
    vecs[4] = '{8'h84, 2, 64'h00000000_00002211, 1'b0, 1'b1, 8'h01, 1, 1'b1};
    vecs[5] = '{8'h84, 1, 64'h00000000_00000077, 1'b1, 1'b1, 8'h01, 1, 1'b0};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; enable = 1'b1; rx_ready = 1'b1;
    wait_clks(5);
    check_reset_outputs("por");
    rst = 1'b0;
    wait_clks(10);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    // Repeated start: two single-byte writes, one STOP, one frame_done.
    begin
      int base;
      base = fd_count;
      rx_ready = 1'b1;
      i2c_start();
      send_byte(8'h84, 1'b1, "sr_addr1");
      sb_q.push_back('{data: 8'h5A, index: 8'd0});
      send_byte(8'h5A, 1'b1, "sr_d0");
      i2c_start();
      check("sr_overrun_cleared", 32'(overrun), 32'd0);
      send_byte(8'h84, 1'b1, "sr_addr2");
      sb_q.push_back('{data: 8'h6B, index: 8'd0});
      send_byte(8'h6B, 1'b1, "sr_d1");
      i2c_stop();
      wait_clks(10);
      check("sr_frame_done_cycles", 32'(fd_count - base), 32'd1);
      check("sr_busy_after_stop", 32'(busy), 32'd0);
      check("sr_sb_empty", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end

    // Reset after 4 data bits, then a clean frame.
    i2c_start();
    send_byte(8'h84, 1'b1, "rst_addr");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    wait_clks(3);
    check_reset_outputs("midrst");
    scl_m = 1'b1;
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(Q);
    rst = 1'b0;
    wait_clks(10);
    check("midrst_busy_after_release", 32'(busy), 32'd0);
    run_vec(vecs[5], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx_ctrl.md
# i2c_slave_rx_ctrl

Parametrised I2C slave write-path receiver for the slave design's Data In component. It oversamples raw SCL/SDA on FPGA_clk, detects START/STOP, matches a 7-bit address, and ACKs/NACKs each byte. Received data bytes go out on a single-entry valid/ready byte interface with backpressure, so the data sink no longer needs a fixed register array. Read requests (R/W=1) are NACKed; a separate block serves them.

## Interface
- SLAVE_ADDR, 7'h42, 7-bit address this slave responds to
- NUM_BYTES, 6, maximum data bytes accepted per frame (1..255); further bytes are NACKed
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA (≥2)

- FPGA_clk  in  1  system clock, ≥10× SCL rate
- rst  in  1  asynchronous, active-high reset
- SCL  in  1  raw bus clock (asynchronous)
- SDA  in  1  raw bus data (asynchronous)
- enable  in  1  slave enabled; sampled only when a START is detected
- sda_pull  out  1  1 = drive SDA low (open-drain enable to pad)
- rx_data  out  8  received data byte, MSB first on the wire
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  sink accepts rx_data when rx_valid & rx_ready
- byte_index  out  8  0-based index of the byte in rx_data within its frame
- busy  out  1  addressed frame in progress (address matched, no STOP yet)
- frame_done  out  1  one-cycle pulse on STOP ending an addressed frame
- overrun  out  1  sticky; a byte was NACKed because rx_valid was still high. Cleared by rst or the next START

## Operation
- SCL/SDA pass through SYNC_STAGES flops, plus one history flop each. Rise/fall events come from synced vs. history.
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. START/STOP detection has priority over data sampling in the same cycle.
- Data bits are sampled on SCL rise. bit_cnt (3 bits) counts 0..7 and wraps after the 8th bit.
- States:
  - IDLE: on START with enable=1 → ADDR. On START with enable=0 → stay.
  - ADDR: shift 8 bits. After the 8th rise:
    - if addr == SLAVE_ADDR and R/W == 0 → ADDR_ACK
    - otherwise → IGNORE, releasing the bus.
  - ADDR_ACK: sda_pull=1 from the next SCL fall until the following SCL fall, then → DATA. busy=1 from entry.
  - DATA: shift 8 bits. At the 8th rise, decide the ACK:
    - ACK if byte_cnt < NUM_BYTES and the output slot is free (rx_valid=0, or rx_valid & rx_ready this cycle). rx_data is loaded, byte_index = byte_cnt, rx_valid=1, byte_cnt+1.
    - Otherwise NACK and drop the byte. Set overrun only if the slot was full. byte_cnt does not increment.
    - Then → DATA_ACK.
  - DATA_ACK: sda_pull=ACK from the next SCL fall until the following SCL fall, then → DATA.
  - IGNORE: sda_pull=0. Wait for STOP or START.
- STOP in any state → IDLE, sda_pull=0, busy=0. frame_done pulses if busy was 1.
- START in any non-IDLE state (repeated start) → ADDR. bit_cnt and byte_cnt clear, overrun clears. busy holds until the address decision. rx_valid/rx_data are untouched.
- byte_cnt is 8 bits and saturates at NUM_BYTES; it never wraps.
- rx_valid clears on rx_valid & rx_ready unless the same cycle loads a new byte, in which case it stays 1 with the new data.

## Timing
- Reset values: sda_pull=0, rx_data=0, rx_valid=0, byte_index=0, busy=0, frame_done=0, overrun=0. Internal FSM=IDLE, counters=0.
- Pin-to-event latency is SYNC_STAGES+1 FPGA_clk cycles (3 with defaults).
- rx_valid rises 1 cycle after the 8th-bit SCL rise event.
- sda_pull asserts 1 cycle after the detected SCL fall following bit 8. It releases 1 cycle after the next detected SCL fall. The hold after SCL fall is ≥ SYNC_STAGES+1 cycles, which satisfies tHD;DAT.
- frame_done asserts 1 cycle after the STOP event and lasts exactly 1 cycle.
- rst may assert mid-frame. All outputs return to reset values immediately, and the slave ignores the bus until the next START.
- A glitch shorter than SYNC_STAGES cycles may be seen. No filter is provided; the bus is assumed to meet I2C rise/fall specs.

## Test plan
- Write frame: address 0x42/W, data A5,3C,FF, rx_ready=1 → three ACKs (SDA low on each 9th clock). rx_data sequence A5,3C,FF with byte_index 0,1,2. frame_done pulses once after STOP; busy falls.
- Address mismatch 0x43/W, then a second case 0x42/R → NACK (sda_pull never asserts). No rx_valid, busy=0, no frame_done.
- Capacity: NUM_BYTES=6, master sends 8 bytes → bytes 0–5 ACKed. Bytes 6–7 NACKed and not output. overrun stays 0.
- Backpressure: rx_ready=0 throughout, 2 bytes 11,22 → byte 11 ACKed and held, byte 22 NACKed, overrun=1. Raising rx_ready delivers 11 only.
- Repeated start: 0x42/W, data 5A, Sr, 0x42/W, data 6B, P → rx_data 5A at byte_index 0, then 6B at byte_index 0. One frame_done.
- Reset mid-byte (after 4 data bits), release, then a full frame 0x42/W,77 → all outputs at reset values during rst. Partial bits are discarded; 77 is received at byte_index 0.
